// File: rtl/read_data_return_pkg.sv
// Shared AXI definitions for the read-data return path: bus widths, slave
// count, master tag encodings, FSM state type and the tag-routing decode.
package read_data_return_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;
  localparam int NUM_S_DEFAULT = 6;

  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ROUTE_M0,
    ROUTE_M1,
    ROUTE_ORPHAN
  } route_t;

  // Upper nibble of a slave RID names the master that issued the read.
  function automatic route_t decode_tag(input logic [3:0] tag);
    case (tag)
      TAG_M0:  return ROUTE_M0;
      TAG_M1:  return ROUTE_M1;
      default: return ROUTE_ORPHAN;
    endcase
  endfunction

endpackage

// File: rtl/read_data_return_if.sv
// R-channel bundle between the slave ports and the two master ports.
// modport master: the return block itself (drives master R beats, slave ready).
// modport slave : the surrounding fabric / models (drives slave R beats).
interface read_data_return_if
  import read_data_return_pkg::*;
#(
  parameter int NUM_S = NUM_S_DEFAULT
);

  logic [NUM_S-1:0][AXI_IDS_BITS-1:0]  rid_s;
  logic [NUM_S-1:0][AXI_DATA_BITS-1:0] rdata_s;
  logic [NUM_S-1:0][1:0]               rresp_s;
  logic [NUM_S-1:0]                    rlast_s;
  logic [NUM_S-1:0]                    rvalid_s;
  logic [NUM_S-1:0]                    rready_s;

  logic [AXI_ID_BITS-1:0]   rid_m0,   rid_m1;
  logic [AXI_DATA_BITS-1:0] rdata_m0, rdata_m1;
  logic [1:0]               rresp_m0, rresp_m1;
  logic                     rlast_m0, rlast_m1;
  logic                     rvalid_m0, rvalid_m1;
  logic                     rready_m0, rready_m1;

  modport master (
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    output rready_s,
    output rid_m0, rdata_m0, rresp_m0, rlast_m0, rvalid_m0,
    output rid_m1, rdata_m1, rresp_m1, rlast_m1, rvalid_m1,
    input  rready_m0, rready_m1
  );

  modport slave (
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
    input  rready_s,
    input  rid_m0, rdata_m0, rresp_m0, rlast_m0, rvalid_m0,
    input  rid_m1, rdata_m1, rresp_m1, rlast_m1, rvalid_m1,
    output rready_m0, rready_m1
  );

endinterface

// File: rtl/read_data_return_rr_arbiter.sv
// Round-robin pick: first requesting index at or after rr_ptr, wrapping
// from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             found
);

  // Scan N positions starting at rr_ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    grant = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/read_data_return.sv
// Read-data return mux: grants one slave R port at a time (round-robin,
// locked for the whole burst) and routes its beats to M0 or M1 by RID tag.
// Beats with an unknown tag are accepted and dropped.
module read_data_return
  import read_data_return_pkg::*;
#(
  parameter int NUM_S = NUM_S_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  read_data_return_if.master bus
);

  localparam int IDX_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_found;
  logic             grant_valid;
  logic             grant_ready;
  route_t           route;

  logic [NUM_S-1:0]         rready_s;
  logic [AXI_ID_BITS-1:0]   rid_m0, rid_m1;
  logic [AXI_DATA_BITS-1:0] rdata_m0, rdata_m1;
  logic [1:0]               rresp_m0, rresp_m1;
  logic                     rlast_m0, rlast_m1;
  logic                     rvalid_m0, rvalid_m1;

  rr_arbiter #(
    .N     (NUM_S),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (bus.rvalid_s),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .found  (arb_found)
  );

  assign grant_valid = bus.rvalid_s[grant_q];
  assign route       = decode_tag(bus.rid_s[grant_q][AXI_IDS_BITS-1:AXI_ID_BITS]);

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: arbitrate in IDLE, release on the last-beat handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          grant_d = arb_grant;
        end
      end
      GRANT: begin
        if (grant_valid && grant_ready && bus.rlast_s[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_S - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pass the granted beat through combinationally; payloads are
  // forced to zero whenever the corresponding master valid is low.
  always_comb begin
    rready_s    = '0;
    grant_ready = 1'b0;
    rid_m0 = '0; rdata_m0 = '0; rresp_m0 = '0; rlast_m0 = 1'b0; rvalid_m0 = 1'b0;
    rid_m1 = '0; rdata_m1 = '0; rresp_m1 = '0; rlast_m1 = 1'b0; rvalid_m1 = 1'b0;
    if (state_q == GRANT) begin
      case (route)
        ROUTE_M0: begin
          grant_ready = bus.rready_m0;
          rvalid_m0   = grant_valid;
          if (grant_valid) begin
            rid_m0   = bus.rid_s[grant_q][AXI_ID_BITS-1:0];
            rdata_m0 = bus.rdata_s[grant_q];
            rresp_m0 = bus.rresp_s[grant_q];
            rlast_m0 = bus.rlast_s[grant_q];
          end
        end
        ROUTE_M1: begin
          grant_ready = bus.rready_m1;
          rvalid_m1   = grant_valid;
          if (grant_valid) begin
            rid_m1   = bus.rid_s[grant_q][AXI_ID_BITS-1:0];
            rdata_m1 = bus.rdata_s[grant_q];
            rresp_m1 = bus.rresp_s[grant_q];
            rlast_m1 = bus.rlast_s[grant_q];
          end
        end
        default: grant_ready = 1'b1;
      endcase
      rready_s[grant_q] = grant_ready;
    end
  end

  assign bus.rready_s  = rready_s;
  assign bus.rid_m0    = rid_m0;
  assign bus.rdata_m0  = rdata_m0;
  assign bus.rresp_m0  = rresp_m0;
  assign bus.rlast_m0  = rlast_m0;
  assign bus.rvalid_m0 = rvalid_m0;
  assign bus.rid_m1    = rid_m1;
  assign bus.rdata_m1  = rdata_m1;
  assign bus.rresp_m1  = rresp_m1;
  assign bus.rlast_m1  = rlast_m1;
  assign bus.rvalid_m1 = rvalid_m1;

endmodule
